// File: rtl/sat_accum_mc_if.sv
// sat_accum_mc_if: request/response handshake and saturation-flag bundle for sat_accum_mc
interface sat_accum_mc_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    logic                in_valid;
    logic                in_ready;
    logic [CHW-1:0]      in_chan;
    logic [1:0]          in_mode;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_sum;
    logic [CHW-1:0]      out_chan;
    logic                out_sat;
    logic [CHANNELS-1:0] sat_flags;
    logic [CHANNELS-1:0] sat_clr;
    logic [15:0]         sat_count;
    modport master (
        output in_valid, in_chan, in_mode, in_a, in_b, out_ready, sat_clr,
        input  in_ready, out_valid, out_sum, out_chan, out_sat, sat_flags, sat_count
    );
    modport slave (
        input  in_valid, in_chan, in_mode, in_a, in_b, out_ready, sat_clr,
        output in_ready, out_valid, out_sum, out_chan, out_sat, sat_flags, sat_count
    );
endinterface

// File: rtl/sat_accum_mc.sv
// sat_accum_mc: multi-channel saturating adder/accumulator with a single registered output stage.
// Define SAT_ACCUM_MC_STATS_EN to build the saturation event counter; otherwise sat_count is tied to 0.
module sat_accum_mc #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SIGNED   = 0
) (
    input logic clk,
    input logic rst,
    sat_accum_mc_if.slave bus
);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    typedef enum logic [1:0] {ADD = 2'b00, ACC = 2'b01, LOAD = 2'b10, DRAIN = 2'b11} mode_t;
    logic [WIDTH-1:0]    acc [CHANNELS];
    logic [CHW-1:0]      chan;
    mode_t               mode;
    logic                accept;
    logic                chan_ok;
    logic                sat;
    logic                res_sat;
    logic [WIDTH-1:0]    cur;
    logic [WIDTH-1:0]    op_x;
    logic [WIDTH-1:0]    op_y;
    logic [WIDTH-1:0]    clamp;
    logic [WIDTH-1:0]    result;
    logic [WIDTH:0]      sum;
    logic [CHANNELS-1:0] sat_set;

    assign chan         = bus.in_chan;
    assign mode         = mode_t'(bus.in_mode);
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Select operands, add one bit wider than the operands, and clamp on overflow
    always_comb begin
        chan_ok = 32'(chan) < CHANNELS;
        cur     = chan_ok ? acc[chan] : '0;
        op_x    = (mode == ADD) ? bus.in_a : cur;
        op_y    = (mode == ADD) ? bus.in_b : bus.in_a;
        sum     = (SIGNED != 0) ? {op_x[WIDTH-1], op_x} + {op_y[WIDTH-1], op_y}
                                : {1'b0, op_x} + {1'b0, op_y};
        sat     = (SIGNED != 0) ? sum[WIDTH] ^ sum[WIDTH-1] : sum[WIDTH];
        clamp   = (SIGNED == 0) ? '1
                : sum[WIDTH]    ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        res_sat = chan_ok && !mode[1] && sat;
        result  = !chan_ok        ? '0
                : (mode == LOAD)  ? bus.in_a
                : (mode == DRAIN) ? cur
                : sat             ? clamp
                                  : sum[WIDTH-1:0];
        sat_set = (accept && res_sat) ? CHANNELS'(1) << chan : '0;
    end

    // Output register: load on accept, drop valid once the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_chan  <= '0;
            bus.out_sat   <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= result;
            bus.out_chan  <= chan;
            bus.out_sat   <= res_sat;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Per-channel accumulators, written at the accept edge so the next request sees the new value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else if (accept && chan_ok && mode != ADD) begin
            acc[chan] <= (mode == DRAIN) ? '0 : result;
        end
    end

    // Sticky saturation flags; a new saturation overrides a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.sat_flags <= '0;
        else     bus.sat_flags <= (bus.sat_flags & ~bus.sat_clr) | sat_set;
    end

`ifdef SAT_ACCUM_MC_STATS_EN
    // Count saturated accepts, holding at the maximum instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              bus.sat_count <= '0;
        else if (accept && res_sat && bus.sat_count != 16'hFFFF) bus.sat_count <= bus.sat_count + 16'd1;
    end
`else
    assign bus.sat_count = 16'h0000;
`endif
endmodule
